uart_io_ctrl: RTL and testbench

UART_IO_CTRL -- requirements
Module: uart_io_ctrl

---
 rtl/uart_io_ctrl_if.sv | 26 ++
 rtl/uart_io_ctrl.sv | 166 ++++++++++++++++
 tb/tb_uart_io_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_io_ctrl_if.sv
// CPU load/store bus plus UART byte handshakes for uart_io_ctrl.
// master = CPU/UART environment, slave = the IO controller.
interface uart_io_ctrl_if;
    logic        stall;
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    modport master (
        output stall, addr, re, we, wdata, tx_ready, rx_data, rx_valid,
        input  rdata, tx_data, tx_valid, rx_ready
    );

    modport slave (
        input  stall, addr, re, we, wdata, tx_ready, rx_data, rx_valid,
        output rdata, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/uart_io_ctrl.sv
// Memory-mapped UART IO controller: TX byte register, RX buffer, free-running cycle counter.
// Define UART_IO_RXFIFO_EN for an RX_FIFO_DEPTH-entry RX FIFO; otherwise RX is a single holding byte.
module uart_io_ctrl #(
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic      Clock,
    input  logic      Reset,
    uart_io_ctrl_if.slave bus
);

    localparam logic [4:0] OFF_TX_STAT   = 5'h00;
    localparam logic [4:0] OFF_RX_STAT   = 5'h04;
    localparam logic [4:0] OFF_TX_DATA   = 5'h08;
    localparam logic [4:0] OFF_RX_DATA   = 5'h0C;
    localparam logic [4:0] OFF_COUNT     = 5'h10;
    localparam logic [4:0] OFF_COUNT_CLR = 5'h18;

    if (RX_FIFO_DEPTH < 2 || RX_FIFO_DEPTH > 64 ||
        (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_badDepth
        $error("RX_FIFO_DEPTH must be a power of two in 2..64");
    end

    logic        ioSel_s;
    logic [4:0]  offset_s;
    logic        rdAcc_s;
    logic        wrAcc_s;
    logic        txLatch_s;
    logic        countClr_s;
    logic [31:0] readMux_s;
    logic [7:0]  rxHead_s;
    logic        rxEmpty_s;
    logic        rxFull_s;
    logic        rxPush_s;
    logic        rxPop_s;
    logic        unusedBits_s;

    logic [31:0] rdata_r;
    logic [7:0]  txData_r;
    logic        txValid_r;
    logic [31:0] cycleCount_r;

    assign ioSel_s      = (bus.addr[31:28] == 4'h8);
    assign offset_s     = bus.addr[4:0];
    assign rdAcc_s      = bus.re && !bus.stall && ioSel_s;
    assign wrAcc_s      = bus.we && !bus.stall && ioSel_s;
    assign txLatch_s    = wrAcc_s && (offset_s == OFF_TX_DATA) && !txValid_r;
    assign countClr_s   = wrAcc_s && (offset_s == OFF_COUNT_CLR);
    assign rxPush_s     = bus.rx_valid && !rxFull_s;
    // An empty-buffer read returns 0 and must not move the read side.
    assign rxPop_s      = rdAcc_s && (offset_s == OFF_RX_DATA) && !rxEmpty_s;
    assign unusedBits_s = ^{bus.addr[27:5], bus.wdata[31:8]};

`ifdef UART_IO_RXFIFO_EN
    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);

    logic [7:0]       rxMem_r [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [PTR_W:0]   rxCount_r;

    assign rxHead_s  = rxMem_r[rdPtr_r];
    assign rxEmpty_s = (rxCount_r == {(PTR_W + 1){1'b0}});
    assign rxFull_s  = (rxCount_r == (PTR_W + 1)'(RX_FIFO_DEPTH));

    // RX FIFO storage; contents are only observed through the counted pointers.
    always_ff @(posedge Clock) begin
        if (rxPush_s) begin
            rxMem_r[wrPtr_r] <= bus.rx_data;
        end
    end

    // RX FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wrPtr_r   <= {PTR_W{1'b0}};
            rdPtr_r   <= {PTR_W{1'b0}};
            rxCount_r <= {(PTR_W + 1){1'b0}};
        end else begin
            if (rxPush_s) begin
                wrPtr_r <= wrPtr_r + PTR_W'(1);
            end
            if (rxPop_s) begin
                rdPtr_r <= rdPtr_r + PTR_W'(1);
            end
            case ({rxPush_s, rxPop_s})
                2'b10:   rxCount_r <= rxCount_r + (PTR_W + 1)'(1);
                2'b01:   rxCount_r <= rxCount_r - (PTR_W + 1)'(1);
                default: rxCount_r <= rxCount_r;
            endcase
        end
    end
`else
    logic [7:0] rxHold_r;
    logic       rxHoldFull_r;

    assign rxHead_s  = rxHold_r;
    assign rxEmpty_s = !rxHoldFull_r;
    assign rxFull_s  = rxHoldFull_r;

    // Single-byte RX holding register; push needs empty and pop needs full, so they never coincide.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rxHold_r     <= 8'h00;
            rxHoldFull_r <= 1'b0;
        end else if (rxPush_s) begin
            rxHold_r     <= bus.rx_data;
            rxHoldFull_r <= 1'b1;
        end else if (rxPop_s) begin
            rxHoldFull_r <= 1'b0;
        end else begin
            rxHoldFull_r <= rxHoldFull_r;
        end
    end
`endif

    // Load data selection by IO offset.
    always_comb begin
        readMux_s = 32'h0000_0000;
        case (offset_s)
            OFF_TX_STAT: readMux_s = {31'd0, !txValid_r};
            OFF_RX_STAT: readMux_s = {31'd0, !rxEmpty_s};
            OFF_RX_DATA: readMux_s = rxEmpty_s ? 32'h0000_0000 : {24'd0, rxHead_s};
            OFF_COUNT:   readMux_s = cycleCount_r;
            default:     readMux_s = 32'h0000_0000;
        endcase
    end

    // Registered load data; holds unless an IO read is accepted.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rdata_r <= 32'h0000_0000;
        end else if (rdAcc_s) begin
            rdata_r <= readMux_s;
        end
    end

    // TX byte register; handshake completion keeps running during a stall.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            txData_r  <= 8'h00;
            txValid_r <= 1'b0;
        end else if (txValid_r && bus.tx_ready) begin
            txValid_r <= 1'b0;
        end else if (txLatch_s) begin
            txData_r  <= bus.wdata[7:0];
            txValid_r <= 1'b1;
        end
    end

    // Free-running cycle counter; clear takes priority over increment.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cycleCount_r <= 32'h0000_0000;
        end else if (countClr_s) begin
            cycleCount_r <= 32'h0000_0000;
        end else begin
            cycleCount_r <= cycleCount_r + 32'd1;
        end
    end

    assign bus.rdata    = rdata_r;
    assign bus.tx_data  = txData_r;
    assign bus.tx_valid = txValid_r;
    assign bus.rx_ready = !rxFull_s;

endmodule

// File: tb/tb_uart_io_ctrl.sv
// Directed self-checking bench for uart_io_ctrl; expectations follow UART_IO_RXFIFO_EN when defined.
module tb_uart_io_ctrl;

    logic Clock;
    logic Reset;
    int   testCount;
    int   failCount;

    uart_io_ctrl_if bus ();

    uart_io_ctrl #(.RX_FIFO_DEPTH(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic ioRead(input logic [4:0] off);
        bus.addr = 32'h8000_0000 | {27'd0, off};
        bus.re   = 1'b1;
        cycle();
        bus.re   = 1'b0;
    endtask

    task automatic ioWrite(input logic [4:0] off, input logic [31:0] data);
        bus.addr  = 32'h8000_0000 | {27'd0, off};
        bus.wdata = data;
        bus.we    = 1'b1;
        cycle();
        bus.we    = 1'b0;
    endtask

    task automatic pushByte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        cycle();
        bus.rx_valid = 1'b0;
    endtask

    initial begin
        testCount    = 0;
        failCount    = 0;
        Reset        = 1'b1;
        bus.stall    = 1'b0;
        bus.addr     = 32'h0000_0000;
        bus.re       = 1'b0;
        bus.we       = 1'b0;
        bus.wdata    = 32'h0000_0000;
        bus.tx_ready = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        cycle();
        cycle();
        check("rst_rdata", bus.rdata, 32'h0);
        check("rst_txvalid", {31'd0, bus.tx_valid}, 32'h0);
        check("rst_txdata", {24'd0, bus.tx_data}, 32'h0);
        check("rst_rxready", {31'd0, bus.rx_ready}, 32'h1);
        Reset = 1'b0;

        // Status and counter straight after reset
        ioRead(5'h00);
        check("txidle_after_rst", bus.rdata, 32'h1);
        ioRead(5'h04);
        check("rxstat_after_rst", bus.rdata, 32'h0);
        ioRead(5'h10);
        check("count_after_rst", bus.rdata, 32'h2);

        // TX: latch, hold under back-pressure, drop second write, handshake
        ioWrite(5'h08, 32'h0000_006C);
        check("tx_valid_set", {31'd0, bus.tx_valid}, 32'h1);
        check("tx_data_6c", {24'd0, bus.tx_data}, 32'h6C);
        ioWrite(5'h08, 32'h0000_0041);
        check("tx_drop_second", {24'd0, bus.tx_data}, 32'h6C);
        ioRead(5'h00);
        check("tx_busy_stat", bus.rdata, 32'h0);
        cycle();
        cycle();
        check("tx_hold_valid", {31'd0, bus.tx_valid}, 32'h1);
        check("tx_hold_data", {24'd0, bus.tx_data}, 32'h6C);
        bus.tx_ready = 1'b1;
        cycle();
        bus.tx_ready = 1'b0;
        check("tx_valid_drop", {31'd0, bus.tx_valid}, 32'h0);
        ioRead(5'h00);
        check("tx_idle_again", bus.rdata, 32'h1);

        // Stalled TX write has no effect
        bus.stall = 1'b1;
        ioWrite(5'h08, 32'h0000_0055);
        bus.stall = 1'b0;
        check("tx_stall_nolatch", {31'd0, bus.tx_valid}, 32'h0);

        // Counter clear, and clear suppressed by stall
        ioWrite(5'h18, 32'h0);
        ioRead(5'h10);
        check("count_clear", bus.rdata, 32'h0);
        bus.stall = 1'b1;
        ioWrite(5'h18, 32'h0);
        bus.stall = 1'b0;
        ioRead(5'h10);
        check("count_stall_noclr", bus.rdata, 32'h2);

        // rdata hold for non-IO and stalled reads, unmapped offset reads 0
        ioRead(5'h00);
        check("rd_tx_stat", bus.rdata, 32'h1);
        bus.addr = 32'h0000_0004;
        bus.re   = 1'b1;
        cycle();
        bus.re   = 1'b0;
        check("rd_nonio_hold", bus.rdata, 32'h1);
        ioRead(5'h14);
        check("rd_unmapped", bus.rdata, 32'h0);
        ioRead(5'h00);
        bus.stall = 1'b1;
        ioRead(5'h04);
        bus.stall = 1'b0;
        check("rd_stall_hold", bus.rdata, 32'h1);

        // RX ordering
`ifdef UART_IO_RXFIFO_EN
        pushByte(8'h7A);
        pushByte(8'h6C);
        pushByte(8'h77);
        ioRead(5'h04);
        check("rx_nonempty", bus.rdata, 32'h1);
        ioRead(5'h0C);
        check("rx_pop1", bus.rdata, 32'h7A);
        ioRead(5'h0C);
        check("rx_pop2", bus.rdata, 32'h6C);
        ioRead(5'h0C);
        check("rx_pop3", bus.rdata, 32'h77);
`else
        pushByte(8'h7A);
        ioRead(5'h04);
        check("rx_nonempty", bus.rdata, 32'h1);
        ioRead(5'h0C);
        check("rx_pop1", bus.rdata, 32'h7A);
        pushByte(8'h6C);
        ioRead(5'h0C);
        check("rx_pop2", bus.rdata, 32'h6C);
        pushByte(8'h77);
        ioRead(5'h0C);
        check("rx_pop3", bus.rdata, 32'h77);
`endif
        ioRead(5'h04);
        check("rx_empty_stat", bus.rdata, 32'h0);
        ioRead(5'h0C);
        check("rx_pop_empty", bus.rdata, 32'h0);

        // Push and pop in the same cycle
        pushByte(8'h11);
        bus.rx_data  = 8'h22;
        bus.rx_valid = 1'b1;
        ioRead(5'h0C);
        bus.rx_valid = 1'b0;
        check("rx_pushpop_head", bus.rdata, 32'h11);
        ioRead(5'h0C);
`ifdef UART_IO_RXFIFO_EN
        check("rx_pushpop_next", bus.rdata, 32'h22);
`else
        check("rx_pushpop_next", bus.rdata, 32'h0);
`endif

        // Stalled RX read does not pop
        pushByte(8'h5A);
        ioRead(5'h00);
        bus.stall = 1'b1;
        ioRead(5'h0C);
        bus.stall = 1'b0;
        check("rx_stall_rdata", bus.rdata, 32'h1);
        ioRead(5'h0C);
        check("rx_stall_nopop", bus.rdata, 32'h5A);

        // Fill to capacity; the next byte waits on the UART side until a pop
`ifdef UART_IO_RXFIFO_EN
        for (int i = 0; i < 8; i++) begin
            pushByte(8'h30 + 8'(i));
        end
        check("rx_full_ready", {31'd0, bus.rx_ready}, 32'h0);
        bus.rx_data  = 8'h38;
        bus.rx_valid = 1'b1;
        cycle();
        check("rx_full_hold", {31'd0, bus.rx_ready}, 32'h0);
        ioRead(5'h0C);
        check("rx_full_pop", bus.rdata, 32'h30);
        check("rx_ready_after_pop", {31'd0, bus.rx_ready}, 32'h1);
        cycle();
        bus.rx_valid = 1'b0;
        check("rx_ninth_taken", {31'd0, bus.rx_ready}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            ioRead(5'h0C);
            check("rx_drain", bus.rdata, 32'h31 + i);
        end
`else
        pushByte(8'h30);
        check("rx_full_ready", {31'd0, bus.rx_ready}, 32'h0);
        bus.rx_data  = 8'h31;
        bus.rx_valid = 1'b1;
        cycle();
        check("rx_full_hold", {31'd0, bus.rx_ready}, 32'h0);
        ioRead(5'h0C);
        check("rx_full_pop", bus.rdata, 32'h30);
        check("rx_ready_after_pop", {31'd0, bus.rx_ready}, 32'h1);
        cycle();
        bus.rx_valid = 1'b0;
        check("rx_second_taken", {31'd0, bus.rx_ready}, 32'h0);
        ioRead(5'h0C);
        check("rx_drain", bus.rdata, 32'h31);
`endif
        ioRead(5'h04);
        check("rx_drained_stat", bus.rdata, 32'h0);

        // Asynchronous reset mid-transfer discards TX and RX state
        ioWrite(5'h08, 32'h0000_0099);
        check("tx_pending", {31'd0, bus.tx_valid}, 32'h1);
        pushByte(8'hA1);
`ifdef UART_IO_RXFIFO_EN
        pushByte(8'hA2);
        pushByte(8'hA3);
`endif
        ioRead(5'h04);
        check("rx_buffered", bus.rdata, 32'h1);
        #2;
        Reset = 1'b1;
        #1;
        check("arst_txvalid", {31'd0, bus.tx_valid}, 32'h0);
        check("arst_txdata", {24'd0, bus.tx_data}, 32'h0);
        check("arst_rxready", {31'd0, bus.rx_ready}, 32'h1);
        check("arst_rdata", bus.rdata, 32'h0);
        cycle();
        Reset = 1'b0;
        ioRead(5'h04);
        check("arst_rx_empty", bus.rdata, 32'h0);
        ioRead(5'h10);
        check("arst_count", bus.rdata, 32'h1);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
